// File: rtl/acc_seq_pkg.sv
// Shared types and encodings for the ACC word-serial sequencer.
package acc_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MULC = 2'd2,
        OP_NOP  = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        IDLE,
        RDA,
        RDB,
        LDB,
        EXE,
        WR,
        SHF,
        WRH,
        DONE
    } state_e;

    localparam logic [1:0] SEL2_FIRST     = 2'b00;
    localparam logic [1:0] SEL2_CARRY     = 2'b01;
    localparam logic [1:0] CARRY_EN_OFF   = 2'b00;
    localparam logic [1:0] CARRY_EN_CHAIN = 2'b01;

    function automatic logic is_mulc(input op_e op);
        return op == OP_MULC;
    endfunction

endpackage

// File: rtl/acc_addr_gen.sv
// Word counter and base+index address adders for the ACC sequencer.
module acc_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int NW_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [NW_W-1:0]   nwords_i,
    input  logic [ADDR_W-1:0] base_a_i,
    input  logic [ADDR_W-1:0] base_b_i,
    input  logic [ADDR_W-1:0] base_r_i,
    input  logic              rd_b_i,
    input  logic              wr_hi_i,
    output logic [ADDR_W-1:0] addrb_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic              first_o,
    output logic              last_o
);

    logic [NW_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0] rd_base;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        i_d = i_q;
        if (load_i) begin
            i_d = '0;
        end else if (inc_i) begin
            i_d = i_q + NW_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
        end else begin
            i_q <= i_d;
        end
    end

    // The high word written after a multiply lands at base_r + n; addresses wrap silently.
    assign rd_base = rd_b_i ? base_b_i : base_a_i;
    assign addrb_o = rd_base + ADDR_W'(i_q);
    assign addra_o = base_r_i + ADDR_W'(wr_hi_i ? nwords_i : i_q);
    assign first_o = (i_q == '0);
    assign last_o  = (i_q == nwords_i - NW_W'(1));

endmodule

// File: rtl/acc_seq.sv
// Word-serial sequencer driving ACC controls and the data RAM port for
// multi-word ADD/SUB with carry chaining and multiply-by-ROM-constant.
module acc_seq
    import acc_seq_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NW_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [NW_W-1:0]   nwords,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [2:0]        rom_sel_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addrb,
    output logic [ADDR_W-1:0] addra,
    output logic              wea,
    output logic              en1,
    output logic              en2,
    output logic              Cen,
    output logic              Cshift,
    output logic              add,
    output logic              sel3,
    output logic              sel4,
    output logic              sel5,
    output logic              sel6,
    output logic              mask,
    output logic [1:0]        sel2,
    output logic [1:0]        carry_en,
    output logic [2:0]        ROM_sel
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [NW_W-1:0]   n_q;
    logic [ADDR_W-1:0] base_a_q, base_b_q, base_r_q;
    logic [2:0]        rom_q;

    logic              load, inc, mulc, first, last;
    logic [ADDR_W-1:0] rd_addr, wr_addr;

    assign load = (state_q == IDLE) && start;
    assign mulc = is_mulc(op_q);
    assign inc  = ((state_q == WR) && !mulc) || (state_q == SHF);

    acc_addr_gen #(
        .ADDR_W (ADDR_W),
        .NW_W   (NW_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .inc_i    (inc),
        .nwords_i (n_q),
        .base_a_i (base_a_q),
        .base_b_i (base_b_q),
        .base_r_i (base_r_q),
        .rd_b_i   (state_q == RDB),
        .wr_hi_i  (state_q == WRH),
        .addrb_o  (rd_addr),
        .addra_o  (wr_addr),
        .first_o  (first),
        .last_o   (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_e'(op) == OP_NOP || nwords == '0) begin
                        state_d = DONE;
                    end else if (op_e'(op) == OP_MULC) begin
                        state_d = RDB;
                    end else begin
                        state_d = RDA;
                    end
                end
            end
            RDA:  state_d = RDB;
            RDB:  state_d = LDB;
            LDB:  state_d = EXE;
            EXE:  state_d = WR;
            WR: begin
                if (mulc) begin
                    state_d = SHF;
                end else begin
                    state_d = last ? DONE : RDA;
                end
            end
            SHF:  state_d = last ? WRH : RDB;
            WRH:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            n_q      <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_r_q <= '0;
            rom_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q     <= op_e'(op);
                n_q      <= nwords;
                base_a_q <= base_a;
                base_b_q <= base_b;
                base_r_q <= base_r;
                rom_q    <= rom_sel_in;
            end
        end
    end

    // Outputs decode only registered state, so reset clears them asynchronously.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        addrb    = '0;
        addra    = '0;
        wea      = 1'b0;
        en1      = 1'b0;
        en2      = 1'b0;
        Cen      = 1'b0;
        Cshift   = 1'b0;
        add      = 1'b0;
        sel3     = 1'b0;
        sel4     = 1'b0;
        sel5     = 1'b0;
        sel2     = SEL2_FIRST;
        carry_en = CARRY_EN_OFF;
        ROM_sel  = '0;
        case (state_q)
            RDA: addrb = rd_addr;
            RDB: begin
                addrb = rd_addr;
                en1   = !mulc;
            end
            LDB: en2 = 1'b1;
            EXE: begin
                Cen = 1'b1;
                if (mulc) begin
                    sel3    = 1'b1;
                    sel4    = 1'b1;
                    ROM_sel = rom_q;
                    sel5    = !first;
                end else begin
                    carry_en = CARRY_EN_CHAIN;
                    add      = (op_q == OP_ADD);
                    sel2     = first ? SEL2_FIRST : SEL2_CARRY;
                end
            end
            WR, WRH: begin
                wea   = 1'b1;
                addra = wr_addr;
            end
            SHF: Cshift = 1'b1;
            default: ;
        endcase
    end

    // Write path always takes the accumulator low word, unmasked.
    assign sel6 = 1'b0;
    assign mask = 1'b0;

endmodule

// File: tb/tb_acc_seq.sv
// Cycle-accurate scoreboard bench for acc_seq: expected control vectors are
// queued at issue and compared one per cycle against the DUT outputs.
module tb_acc_seq;

    logic       clk, rst_n, start;
    logic [1:0] op;
    logic [3:0] nwords;
    logic [9:0] base_a, base_b, base_r;
    logic [2:0] rom_sel_in;
    logic       busy, done, wea, en1, en2, Cen, Cshift, add;
    logic       sel3, sel4, sel5, sel6, mask;
    logic [9:0] addrb, addra;
    logic [1:0] sel2, carry_en;
    logic [2:0] ROM_sel;

    typedef struct packed {
        logic       busy, done;
        logic [9:0] addrb, addra;
        logic       wea, en1, en2, cen, cshift, add, sel3, sel4, sel5, sel6, mask;
        logic [1:0] sel2, carry_en;
        logic [2:0] rom_sel;
    } ctl_t;

    ctl_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    acc_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .nwords     (nwords),
        .base_a     (base_a),
        .base_b     (base_b),
        .base_r     (base_r),
        .rom_sel_in (rom_sel_in),
        .busy       (busy),
        .done       (done),
        .addrb      (addrb),
        .addra      (addra),
        .wea        (wea),
        .en1        (en1),
        .en2        (en2),
        .Cen        (Cen),
        .Cshift     (Cshift),
        .add        (add),
        .sel3       (sel3),
        .sel4       (sel4),
        .sel5       (sel5),
        .sel6       (sel6),
        .mask       (mask),
        .sel2       (sel2),
        .carry_en   (carry_en),
        .ROM_sel    (ROM_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t s;
        s = '{busy: busy, done: done, addrb: addrb, addra: addra, wea: wea,
              en1: en1, en2: en2, cen: Cen, cshift: Cshift, add: add,
              sel3: sel3, sel4: sel4, sel5: sel5, sel6: sel6, mask: mask,
              sel2: sel2, carry_en: carry_en, rom_sel: ROM_sel};
        return s;
    endfunction

    // Expected per-cycle control trace from acceptance+1 through the idle cycle after DONE.
    function automatic void push_cmd(input int o, input int n, input logic [9:0] ba,
                                     input logic [9:0] bb, input logic [9:0] br,
                                     input logic [2:0] rom);
        ctl_t e;
        if (o == 3 || n == 0) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (o != 2) begin
                    e = '0; e.busy = 1'b1; e.addrb = 10'(ba + i); exp_q.push_back(e);
                    e = '0; e.busy = 1'b1; e.addrb = 10'(bb + i); e.en1 = 1'b1; exp_q.push_back(e);
                end else begin
                    e = '0; e.busy = 1'b1; e.addrb = 10'(bb + i); exp_q.push_back(e);
                end
                e = '0; e.busy = 1'b1; e.en2 = 1'b1; exp_q.push_back(e);
                e = '0; e.busy = 1'b1; e.cen = 1'b1;
                if (o == 2) begin
                    e.sel3 = 1'b1; e.sel4 = 1'b1; e.rom_sel = rom; e.sel5 = (i != 0);
                end else begin
                    e.carry_en = 2'b01; e.add = (o == 0); e.sel2 = (i == 0) ? 2'b00 : 2'b01;
                end
                exp_q.push_back(e);
                e = '0; e.busy = 1'b1; e.wea = 1'b1; e.addra = 10'(br + i); exp_q.push_back(e);
                if (o == 2) begin
                    e = '0; e.busy = 1'b1; e.cshift = 1'b1; exp_q.push_back(e);
                end
            end
            if (o == 2) begin
                e = '0; e.busy = 1'b1; e.wea = 1'b1; e.addra = 10'(br + n); exp_q.push_back(e);
            end
            e = '0; e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e);
        end
        e = '0;
        exp_q.push_back(e);
    endfunction

    // Called at a negedge; returns at the negedge of the idle cycle after DONE.
    task automatic run_cmd(input int o, input int n, input logic [9:0] ba, input logic [9:0] bb,
                           input logic [9:0] br, input logic [2:0] rom,
                           input int glitch, input int abort_at);
        ctl_t e;
        int   j;
        push_cmd(o, n, ba, bb, br, rom);
        op = 2'(o); nwords = 4'(n); base_a = ba; base_b = bb; base_r = br; rom_sel_in = rom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = 0;
        while (exp_q.size() > 0) begin
            if (j > 0) @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("op%0d n%0d cyc%0d", o, n, j), sample(), e);
            if (j == glitch) begin
                start = 1'b1; op = 2'd2; nwords = 4'd9;
                base_a = 10'h155; base_b = 10'h2AA; base_r = 10'h0F0; rom_sel_in = 3'd7;
            end else begin
                start = 1'b0;
            end
            if (j == abort_at) begin
                #1 rst_n = 1'b0;
                #1 check("abort_same_cycle", sample(), '0);
                exp_q.delete();
                repeat (3) begin
                    @(negedge clk);
                    check("abort_held", sample(), '0);
                end
                rst_n = 1'b1;
            end
            j++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; nwords = '0;
        base_a = '0; base_b = '0; base_r = '0; rom_sel_in = '0;
        #1 check("reset", sample(), '0);
        repeat (2) @(negedge clk);
        check("reset_held", sample(), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD n=2 with a stray start (and changed inputs) mid-command
        run_cmd(0, 2, 10'h010, 10'h020, 10'h030, 3'd0, 3, -1);
        // SUB n=1, then MULC n=2 back-to-back
        run_cmd(1, 1, 10'h040, 10'h041, 10'h042, 3'd0, -1, -1);
        run_cmd(2, 2, 10'h000, 10'h050, 10'h060, 3'd3, -1, -1);
        // Degenerate commands
        run_cmd(0, 0, 10'h100, 10'h101, 10'h102, 3'd0, -1, -1);
        run_cmd(3, 3, 10'h100, 10'h101, 10'h102, 3'd0, -1, -1);
        // MULC with result addresses wrapping past the top of RAM
        run_cmd(2, 3, 10'h000, 10'h3FE, 10'h3FF, 3'd5, -1, -1);
        // Maximum word count
        run_cmd(0, 15, 10'h200, 10'h3F8, 10'h300, 3'd0, -1, -1);
        // Reset during EXE of word 1 of a 3-word ADD, then recovery
        run_cmd(0, 3, 10'h070, 10'h080, 10'h090, 3'd0, -1, 8);
        run_cmd(1, 2, 10'h0A0, 10'h0B0, 10'h0C0, 3'd0, -1, -1);

        repeat (3) begin
            @(negedge clk);
            check("idle_tail", sample(), '0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_seq.md
# acc_seq

Word-serial sequencer that drives the control inputs of the ACC arithmetic datapath and the data RAM port. It runs multi-word operations on 16-bit words held in RAM:
- ADD and SUB, with carry or borrow chained across words.
- MULC, multiplication of a multi-word operand by a ROM constant.

It sits between the top-level cryptoprocessor FSM, which issues a command with `start`, and ACC plus the data RAM. It owns the word loop, RAM addressing and the carry/accumulator bookkeeping.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM address width.
- `NW_W`, default 4: width of the word-count field. At most 2^NW_W-1 words per command.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  command strobe. Sampled only in IDLE.
- `op`  in  2  command code: 0 ADD, 1 SUB, 2 MULC, 3 NOP.
- `nwords`  in  NW_W  operand length in words.
- `base_a`, `base_b`, `base_r`  in  ADDR_W each  operand A, operand B and result base addresses.
- `rom_sel_in`  in  3  constant select for MULC.
- `busy`  out  1  high from the cycle after acceptance until DONE inclusive.
- `done`  out  1  one-cycle pulse in DONE.
- `addrb`  out  ADDR_W  RAM read address. Data arrives on ACC `doutb` one cycle later.
- `addra`  out  ADDR_W  RAM write address.
- `wea`  out  1  RAM write enable. Write data is ACC `dina`.
- `en1`, `en2`, `Cen`, `Cshift`, `add`, `sel3`, `sel4`, `sel5`, `sel6`, `mask`  out  1 each  ACC controls.
- `sel2`  out  2  ACC control.
- `carry_en`  out  2  ACC control.
- `ROM_sel`  out  3  ACC control.

## Operation
- **Reset.** All outputs are 0 and the FSM is in IDLE. Assertion of `rst_n` mid-command aborts immediately: outputs go to 0 asynchronously, no further writes occur, and no `done` is issued.
- **Command capture.** On acceptance (IDLE and `start`), `op`, `nwords`, the three bases and `rom_sel_in` are registered. Word index `i` is set to 0.
- **`start` while busy** is ignored.
- **`nwords`==0 or `op`==NOP:** go straight to DONE. No RAM writes.
- **ADD/SUB states, per word `i`:**
  - RDA: `addrb`=`base_a`+`i`.
  - RDB: `addrb`=`base_b`+`i`; `en1`=1.
  - LDB: `en2`=1.
  - EXE: `Cen`=1, `sel3`=0, `carry_en`=01, `add`=(op==ADD). `sel2`=00 when `i`==0, otherwise 01 (carry-in from `carryout1`).
  - WR: `wea`=1, `addra`=`base_r`+`i`, `sel6`=0, `mask`=0. Then `i`++; go to RDA if `i`<n, else DONE.
  - Final carry/borrow is discarded. The result is n words.
- **MULC states, per word `i`:**
  - RDB: `addrb`=`base_b`+`i`.
  - LDB: `en2`=1.
  - EXE: `Cen`=1, `sel3`=1, `sel4`=1, `ROM_sel`=registered constant, `sel5`=(`i`!=0).
  - WR: writes word `i`, as in ADD/SUB.
  - SHF: `Cshift`=1. Then `i`++; go to RDB if `i`<n.
  - After the last SHF: WRH writes CL to `base_r`+n, then DONE. The result is n+1 words.
- **Idle controls.** Every ACC control not listed for a state is 0 in that state.
- **ACC inputs not driven here** are tied at integration: `sel1`=0, `sel7`=0, `R1set`=0, `clr1`=0, `clr2`=0, `mode`=0.
- **Address arithmetic** is modulo 2^ADDR_W. Wrap-around is not flagged.

## Timing
- All outputs are registered-state decodes (Moore). There are no combinational paths from inputs to outputs.
- Command accepted at edge k puts the FSM in its first work state in cycle k+1.
- `done` is high in cycle k+1+5n for ADD/SUB, and k+2+5n for MULC. For NOP or n=0 it is high in cycle k+1.
- `busy` falls with the exit from DONE. A new `start` is accepted in the cycle after DONE, giving back-to-back issue with one idle cycle.
- Read latency: the word addressed in RDA (RDB for MULC) is latched by `en1` (`en2`) in the following state.

## Structure
- Package `acc_seq_pkg` holds:
  - op codes ADD/SUB/MULC/NOP;
  - state enum IDLE, RDA, RDB, LDB, EXE, WR, SHF, WRH, DONE;
  - constants for the `sel2` and `carry_en` encodings.
- One sub-module, `acc_addr_gen`, holds the word counter `i`, the last-word compare, and the base+`i` adders for `addrb` and `addra`. It takes load/increment inputs from the FSM.

## Test plan
- ADD, n=2: A=0x0001_FFFF, B=0x0000_0001 → result 0x0002_0000. `wea` high twice, at `base_r` and `base_r`+1; `done` at k+11.
- SUB, n=1: A=0x0005, B=0x0007 → result 0xFFFE. `sel2`=00 in the single EXE.
- MULC, n=2, constant 3: B=0x8000_8000 → words 0x8000, 0x8001, 0x0001. `Cshift` pulses twice; `done` at k+12.
- `nwords`=0 and `op`=NOP: `done` at k+1, `wea` never asserted. A `start` pulse during a busy ADD is ignored: exactly n writes occur.
- `rst_n` low in the EXE of word 1 of a 3-word ADD: all outputs 0 the same cycle; no `done`. After release, a new command runs correctly.
